// File: rtl/hv_pkg.sv
// Shared widths, FSM state encoding and the per-channel step rule for the HV setpoint ramp.
package hv_pkg;
    localparam int NCH   = 32;
    localparam int HVW   = 10;
    localparam int ADDRW = 5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        SCAN,
        START,
        HOLD
    } state_e;

    // Move cur toward tgt by at most step; with ramping disabled, jump straight to tgt.
    function automatic logic [HVW-1:0] step_toward(
        input logic [HVW-1:0] cur,
        input logic [HVW-1:0] tgt,
        input logic           ramp_en,
        input logic [HVW-1:0] step
    );
        logic [HVW-1:0] diff;
        logic [HVW-1:0] res;
        res = tgt;
        if (ramp_en) begin
            if (tgt >= cur) begin
                diff = tgt - cur;
                if (diff > step) res = cur + step;
            end else begin
                diff = cur - tgt;
                if (diff > step) res = cur - step;
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/hv_ramp_tick.sv
// Free-running RAMP_DIV prescaler; tick is high for the single cycle where the count is RAMP_DIV-1.
module hv_ramp_tick #(
    parameter int RAMP_DIV = 1000
) (
    input  logic sclk,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(RAMP_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(RAMP_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge sclk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/hv_setpoint_ramp.sv
// Setpoint store and ramp FSM feeding the DAC serial FSM: steps 32 current values toward their
// targets one channel per cycle, then requests a DAC update and freezes the values while it runs.
module hv_setpoint_ramp
    import hv_pkg::*;
#(
    parameter int RAMP_DIV    = 1000,
    parameter int STEP        = 8,
    parameter int HOLD_CYCLES = 200
) (
    input  logic                 sclk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDRW-1:0]     wr_addr,
    input  logic [HVW-1:0]       wr_data,
    input  logic                 ramp_en,
    output logic [NCH*HVW-1:0]   hv_reg,
    output logic                 ap_start,
    output logic                 ramp_active
);
    localparam int             HCW    = $clog2(HOLD_CYCLES);
    localparam logic [HVW-1:0] STEP_W = HVW'(STEP);

    state_e             state_q, state_d;
    logic [HVW-1:0]     tgt_q [NCH];
    logic [HVW-1:0]     tgt_d [NCH];
    logic [HVW-1:0]     cur_q [NCH];
    logic [HVW-1:0]     cur_d [NCH];
    logic [ADDRW-1:0]   idx_q, idx_d;
    logic [HCW-1:0]     hold_q, hold_d;
    logic               dirty_q, dirty_d;
    logic               changed_q, changed_d;
    logic               pending_q, pending_d;
    logic               ap_start_q, ap_start_d;
    logic               ramp_active_q, ramp_active_d;
    logic               tick;
    logic               wr_accept;
    logic               changed_now;
    logic [HVW-1:0]     cur_sel, tgt_sel, cur_new;

    hv_ramp_tick #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .sclk  (sclk),
        .reset (reset),
        .tick  (tick)
    );

    assign wr_ready    = (state_q != SCAN);
    assign ap_start    = ap_start_q;
    assign ramp_active = ramp_active_q;

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        cur_d       = cur_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        dirty_d     = dirty_q;
        changed_d   = changed_q;
        pending_d   = pending_q;
        changed_now = changed_q;
        wr_accept   = wr_valid && wr_ready;
        cur_sel     = cur_q[idx_q];
        tgt_sel     = tgt_q[idx_q];
        cur_new     = step_toward(cur_sel, tgt_sel, ramp_en, STEP_W);

        if (wr_accept) begin
            tgt_d[wr_addr] = wr_data;
            dirty_d        = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (dirty_q) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (tick) begin
                    state_d   = SCAN;
                    idx_d     = '0;
                    changed_d = 1'b0;
                    pending_d = 1'b0;
                    dirty_d   = wr_accept;
                end
            end
            SCAN: begin
                cur_d[idx_q] = cur_new;
                changed_now  = changed_q || (cur_sel != tgt_sel);
                changed_d    = changed_now;
                if (cur_new != tgt_sel) pending_d = 1'b1;
                idx_d = idx_q + ADDRW'(1);
                if (idx_q == ADDRW'(NCH - 1)) begin
                    if (changed_now)  state_d = START;
                    else if (dirty_q) state_d = WAIT_TICK;
                    else              state_d = IDLE;
                end
            end
            START: begin
                hold_d  = HCW'(HOLD_CYCLES - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = (pending_q || dirty_d) ? WAIT_TICK : IDLE;
                end else begin
                    hold_d = hold_q - HCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ap_start_d    = (state_d == START);
        ramp_active_d = (state_d != IDLE);
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q       <= IDLE;
            tgt_q         <= '{default: '0};
            cur_q         <= '{default: '0};
            idx_q         <= '0;
            hold_q        <= '0;
            dirty_q       <= 1'b0;
            changed_q     <= 1'b0;
            pending_q     <= 1'b0;
            ap_start_q    <= 1'b0;
            ramp_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tgt_q         <= tgt_d;
            cur_q         <= cur_d;
            idx_q         <= idx_d;
            hold_q        <= hold_d;
            dirty_q       <= dirty_d;
            changed_q     <= changed_d;
            pending_q     <= pending_d;
            ap_start_q    <= ap_start_d;
            ramp_active_q <= ramp_active_d;
        end
    end

    always_comb begin
        hv_reg = '0;
        for (int i = 0; i < NCH; i++) hv_reg[i*HVW +: HVW] = cur_q[i];
    end
endmodule

// File: tb/tb_hv_setpoint_ramp.sv
// Self-checking bench for hv_setpoint_ramp: directed scenarios plus randomized writes against a pass-level model.
module tb_hv_setpoint_ramp;
    localparam int RAMP_DIV    = 64;
    localparam int STEP        = 8;
    localparam int HOLD_CYCLES = 200;

    logic         sclk = 1'b0;
    logic         reset;
    logic         wr_valid;
    logic         wr_ready;
    logic [4:0]   wr_addr;
    logic [9:0]   wr_data;
    logic         ramp_en;
    logic [319:0] hv_reg;
    logic         ap_start;
    logic         ramp_active;

    int           checks = 0;
    int           errors = 0;
    int           m_tgt[32];
    int           m_cur[32];
    int           ap_cnt = 0;
    longint       cyc = 0;
    longint       last_ap = 0;
    bit           have_last = 0;
    logic [319:0] ap_hist[$];

    hv_setpoint_ramp #(.RAMP_DIV(RAMP_DIV), .STEP(STEP), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .sclk        (sclk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ramp_en     (ramp_en),
        .hv_reg      (hv_reg),
        .ap_start    (ap_start),
        .ramp_active (ramp_active)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc++;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] pack_model(input bit use_tgt);
        logic [319:0] v;
        for (int i = 0; i < 32; i++) v[i*10 +: 10] = 10'(use_tgt ? m_tgt[i] : m_cur[i]);
        return v;
    endfunction

    function automatic int chan(input logic [319:0] v, input int i);
        return int'(v[i*10 +: 10]);
    endfunction

    // One DAC update request means one completed pass: advance the model by a pass and compare.
    always @(negedge sclk) begin
        if (ap_start === 1'b1) begin
            for (int i = 0; i < 32; i++) begin
                int d;
                d = m_tgt[i] - m_cur[i];
                if (!ramp_en || (d <= STEP && d >= -STEP)) m_cur[i] = m_tgt[i];
                else if (d > 0)                            m_cur[i] = m_cur[i] + STEP;
                else                                       m_cur[i] = m_cur[i] - STEP;
            end
            check_eq("pass_hv_reg", hv_reg, pack_model(0));
            if (have_last) check_eq("ap_gap", 320'(cyc - last_ap >= HOLD_CYCLES + 1), 320'(1));
            have_last = 1;
            last_ap   = cyc;
            ap_cnt++;
            ap_hist.push_back(hv_reg);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_tgt[i] = 0;
            m_cur[i] = 0;
        end
        have_last = 0;
    endtask

    task automatic wr(input int a, input int d);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = 5'(a);
        wr_data  = 10'(d);
        while (wr_ready !== 1'b1 && n < 1000) begin
            @(negedge sclk);
            n++;
        end
        check_eq("wr_accept_bound", 320'(n < 1000), 320'(1));
        @(posedge sclk);
        m_tgt[a] = d;
        @(negedge sclk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int zeros = 0;
        int n = 0;
        while (zeros < 4 && n < 20000) begin
            @(negedge sclk);
            n++;
            zeros = ramp_active ? 0 : zeros + 1;
        end
        check_eq("idle_reached", 320'(n < 20000), 320'(1));
    endtask

    task automatic wait_scan();
        int n = 0;
        while (wr_ready !== 1'b0 && n < 5000) begin
            @(negedge sclk);
            n++;
        end
        check_eq("scan_reached", 320'(n < 5000), 320'(1));
    endtask

    task automatic wait_ap();
        int n = 0;
        while (ap_start !== 1'b1 && n < 5000) begin
            @(negedge sclk);
            n++;
        end
        check_eq("ap_reached", 320'(n < 5000), 320'(1));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge sclk);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #(95000 * 10);
        errors++;
        $display("FAIL watchdog cycles=%0d limit=95000", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int base, cnt, a, d;
        logic [319:0] snap;
        bit frozen;

        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; ramp_en = 1'b1;
        model_clear();
        @(negedge sclk);

        // Reset with a write attempt that must be ignored
        for (int i = 0; i < 5; i++) begin
            wr_valid = (i == 2);
            wr_addr  = 5'd3;
            wr_data  = 10'h3FF;
            @(negedge sclk);
        end
        wr_valid = 1'b0;
        reset    = 1'b0;
        check_eq("rst_hv_reg", hv_reg, '0);
        check_eq("rst_ap_start", 320'(ap_start), 320'(0));
        check_eq("rst_ramp_active", 320'(ramp_active), 320'(0));
        check_eq("rst_wr_ready", 320'(wr_ready), 320'(1));
        repeat (RAMP_DIV + 60) @(negedge sclk);
        check_eq("rst_write_ignored_ap", 320'(ap_cnt), 320'(0));
        check_eq("rst_write_ignored_hv", hv_reg, '0);
        check_eq("rst_still_idle", 320'(ramp_active), 320'(0));

        // Bounded upward ramp
        ramp_en = 1'b1;
        base = ap_cnt;
        wr(5, 20);
        wait_idle();
        check_eq("ramp_pulses", 320'(ap_cnt - base), 320'(3));
        check_eq("ramp_pass1", 320'(chan(ap_hist[base], 5)), 320'(8));
        check_eq("ramp_pass2", 320'(chan(ap_hist[base + 1], 5)), 320'(16));
        check_eq("ramp_pass3", 320'(chan(ap_hist[base + 2], 5)), 320'(20));
        repeat (2 * RAMP_DIV + 50) @(negedge sclk);
        check_eq("ramp_no_extra", 320'(ap_cnt - base), 320'(3));

        // Direct jump
        ramp_en = 1'b0;
        base = ap_cnt;
        wr(31, 10'h3FF);
        wr(0, 1);
        wait_idle();
        check_eq("jump_pulses", 320'(ap_cnt - base), 320'(1));
        check_eq("jump_ch31", 320'(hv_reg[319:310]), 320'(10'h3FF));
        check_eq("jump_ch0", 320'(hv_reg[9:0]), 320'(1));

        // Downward ramp, then a no-change rewrite
        wr(7, 100);
        wait_idle();
        ramp_en = 1'b1;
        base = ap_cnt;
        wr(7, 90);
        wait_idle();
        check_eq("down_pulses", 320'(ap_cnt - base), 320'(2));
        check_eq("down_pass1", 320'(chan(ap_hist[base], 7)), 320'(92));
        check_eq("down_pass2", 320'(chan(ap_hist[base + 1], 7)), 320'(90));
        base = ap_cnt;
        wr(7, 90);
        wait_idle();
        check_eq("rewrite_no_ap", 320'(ap_cnt - base), 320'(0));

        // Write held across a scan, then a write during hold
        wr(9, 40);
        wait_scan();
        wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 10'd33;
        cnt = 0;
        while (wr_ready === 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge sclk);
        end
        check_eq("scan_ready_low_len", 320'(cnt), 320'(32));
        @(posedge sclk);
        m_tgt[10] = 33;
        @(negedge sclk);
        wr_valid = 1'b0;
        wr(2, 50);
        snap = hv_reg;
        frozen = 1;
        cnt = 0;
        while (wr_ready !== 1'b0 && cnt < 5000) begin
            if (hv_reg !== snap) frozen = 0;
            @(negedge sclk);
            cnt++;
        end
        check_eq("hold_frozen", 320'(frozen), 320'(1));
        wait_ap();
        check_eq("hold_write_ch2", 320'(chan(hv_reg, 2)), 320'(8));
        check_eq("scan_end_write_ch10", 320'(chan(hv_reg, 10)), 320'(8));
        wait_idle();

        // Reset during HOLD
        wr(4, 200);
        wait_ap();
        repeat (10) @(negedge sclk);
        base = ap_cnt;
        do_reset(1);
        check_eq("hold_rst_hv", hv_reg, '0);
        check_eq("hold_rst_active", 320'(ramp_active), 320'(0));
        @(negedge sclk);
        check_eq("hold_rst_ap", 320'(ap_start), 320'(0));
        repeat (RAMP_DIV + 50) @(negedge sclk);
        check_eq("hold_rst_quiet", 320'(ap_cnt - base), 320'(0));

        // Reset in SCAN at idx 17
        wr(6, 300);
        wait_scan();
        repeat (17) @(negedge sclk);
        base = ap_cnt;
        do_reset(1);
        check_eq("scan_rst_hv", hv_reg, '0);
        check_eq("scan_rst_active", 320'(ramp_active), 320'(0));
        @(negedge sclk);
        check_eq("scan_rst_ap", 320'(ap_start), 320'(0));
        repeat (RAMP_DIV + 50) @(negedge sclk);
        check_eq("scan_rst_quiet", 320'(ap_cnt - base), 320'(0));

        // Randomized writes against the pass-level model
        for (int it = 0; it < 12; it++) begin
            ramp_en = 1'($urandom_range(0, 1));
            for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
                a = int'($urandom_range(0, 31));
                if (ramp_en) begin
                    d = m_tgt[a] + int'($urandom_range(0, 96)) - 48;
                    if (d < 0) d = 0;
                    if (d > 1023) d = 1023;
                end else begin
                    d = int'($urandom_range(0, 1023));
                end
                wr(a, d);
                repeat ($urandom_range(0, 300)) @(negedge sclk);
            end
            wait_idle();
            check_eq("rand_settled_tgt", hv_reg, pack_model(1));
            check_eq("rand_settled_model", hv_reg, pack_model(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
